// File: rtl/noc_host_interface.sv
// noc_host_interface
// Host-side bridge for the NoC local port at router (0,0).
//   TX: host valid/ready stream -> packet FIFO -> 4-phase bundled-data
//       injection into the NoC IN channel.
//   RX: 4-phase bundled-data reception from the NoC OUT channel ->
//       packet FIFO -> host valid/ready stream.
// The two paths share only the clock and reset.
//
// Handshake semantics (host side, both directions): a transfer happens on
// a rising clock edge where valid and ready are both high. The TX side
// presents o_tx_ready from registered state only, so the host may hold
// i_tx_valid high and wait. On the RX side, o_rx_valid/o_rx_data stay
// stable until the edge where i_rx_ready is seen high.
//
// NoC side: 4-phase return-to-zero. Data is driven before the request
// rises and held until the acknowledge has risen. The incoming handshake
// signals are asynchronous to i_clk and each passes through SYNC_STAGES
// flops (SYNC_STAGES must be at least 2).
module noc_host_interface #(
  parameter int          WIDTH       = 39,
  parameter int          DEPTH       = 4,
  parameter logic [7:0]  SRC_ADDR    = 8'h00,
  parameter int          SYNC_STAGES = 2,
  localparam int         AW          = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  // host TX stream
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic [7:0]       i_tx_dst,
  input  logic [2:0]       i_tx_type,
  input  logic [19:0]      i_tx_payload,
  // NoC IN channel (we are the requester)
  output logic             o_noc_in_req,
  output logic [WIDTH-1:0] o_noc_in_data,
  input  logic             i_noc_in_ack,
  // NoC OUT channel (we are the acknowledger)
  input  logic             i_noc_out_req,
  input  logic [WIDTH-1:0] i_noc_out_data,
  output logic             o_noc_out_ack,
  // host RX stream
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  // status
  output logic [AW:0]      o_tx_level,
  output logic [AW:0]      o_rx_level,
  output logic [15:0]      o_pkt_sent,
  output logic [15:0]      o_pkt_recv,
  // FSM state visibility for checkers
  output logic [1:0]       o_dbg_tx_state,
  output logic             o_dbg_rx_state
);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_SETUP = 2'd1,
    T_REQ   = 2'd2,
    T_REL   = 2'd3
  } tx_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_ACK  = 1'b1
  } rx_state_t;

  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0] CNT_ONE  = 16'd1;

  // ---------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------
  tx_state_t        r_tx_state;
  rx_state_t        r_rx_state;

  logic [WIDTH-1:0] r_tx_mem [DEPTH];
  logic [AW:0]      r_tx_wptr;
  logic [AW:0]      r_tx_rptr;
  logic [AW:0]      w_tx_level;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_tx_push;
  logic             w_tx_pop;
  logic [WIDTH-1:0] w_tx_pkt;

  logic [WIDTH-1:0] r_rx_mem [DEPTH];
  logic [AW:0]      r_rx_wptr;
  logic [AW:0]      r_rx_rptr;
  logic [AW:0]      w_rx_level;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_rx_write;
  logic             w_rx_pop;

  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [SYNC_STAGES-1:0] r_req_sync;
  logic                   w_ack_s;
  logic                   w_req_s;

  logic             r_noc_in_req;
  logic [WIDTH-1:0] r_noc_in_data;
  logic             r_noc_out_ack;
  logic [15:0]      r_pkt_sent;
  logic [15:0]      r_pkt_recv;

  // ---------------------------------------------------------------------
  // Packet assembly: destination, our source address, type, payload
  // ---------------------------------------------------------------------
  assign w_tx_pkt = {i_tx_dst, SRC_ADDR, i_tx_type, i_tx_payload};

  // ---------------------------------------------------------------------
  // TX FIFO status. Pointers carry one extra wrap bit so that the
  // difference is the occupancy directly.
  // ---------------------------------------------------------------------
  assign w_tx_level = r_tx_wptr - r_tx_rptr;
  assign w_tx_full  = (w_tx_level == LVL_FULL);
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  // A pop on the same edge does not free a slot for a push while full.
  assign w_tx_push  = i_tx_valid && !w_tx_full;
  assign w_tx_pop   = (r_tx_state == T_IDLE) && !w_tx_empty;

  // TX FIFO storage write; contents need no reset because the pointers gate them
  always_ff @(posedge i_clk) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[AW-1:0]] <= w_tx_pkt;
    end
  end

  // TX FIFO pointers: host pushes, TX FSM pops when it loads a packet
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) begin
        r_tx_wptr <= r_tx_wptr + PTR_ONE;
      end
      if (w_tx_pop) begin
        r_tx_rptr <= r_tx_rptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Synchronizers for the two handshake inputs that come from the NoC
  // ---------------------------------------------------------------------
  // Shift each asynchronous handshake input through its flop chain
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ack_sync <= '0;
      r_req_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_noc_in_ack};
      r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], i_noc_out_req};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
  assign w_req_s = r_req_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // TX FSM. Data is registered one full cycle before req rises and is
  // only reloaded from T_IDLE, so it is stable for the whole handshake.
  // ---------------------------------------------------------------------
  // Drive the NoC IN 4-phase handshake and count completed injections
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state    <= T_IDLE;
      r_noc_in_req  <= 1'b0;
      r_noc_in_data <= '0;
      r_pkt_sent    <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          if (!w_tx_empty) begin
            r_noc_in_data <= r_tx_mem[r_tx_rptr[AW-1:0]];
            r_tx_state    <= T_SETUP;
          end
        end
        T_SETUP: begin
          r_noc_in_req <= 1'b1;
          r_tx_state   <= T_REQ;
        end
        T_REQ: begin
          if (w_ack_s) begin
            r_noc_in_req <= 1'b0;
            r_tx_state   <= T_REL;
          end
        end
        T_REL: begin
          // Wait for the return-to-zero phase before the next packet.
          if (!w_ack_s) begin
            r_pkt_sent <= r_pkt_sent + CNT_ONE;
            r_tx_state <= T_IDLE;
          end
        end
        default: begin
          r_tx_state <= T_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO status
  // ---------------------------------------------------------------------
  assign w_rx_level = r_rx_wptr - r_rx_rptr;
  assign w_rx_full  = (w_rx_level == LVL_FULL);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  // Accept only with room; otherwise the NoC sender is held by a low ack.
  assign w_rx_write = (r_rx_state == R_IDLE) && w_req_s && !w_rx_full;
  assign w_rx_pop   = !w_rx_empty && i_rx_ready;

  // RX FIFO storage write of the bundled NoC data while req is held
  always_ff @(posedge i_clk) begin
    if (w_rx_write) begin
      r_rx_mem[r_rx_wptr[AW-1:0]] <= i_noc_out_data;
    end
  end

  // RX FIFO pointers: RX FSM writes, host pops; both may happen together
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_wptr <= '0;
      r_rx_rptr <= '0;
    end else begin
      if (w_rx_write) begin
        r_rx_wptr <= r_rx_wptr + PTR_ONE;
      end
      if (w_rx_pop) begin
        r_rx_rptr <= r_rx_rptr + PTR_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  // Answer the NoC OUT 4-phase handshake and count completed receptions
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_state    <= R_IDLE;
      r_noc_out_ack <= 1'b0;
      r_pkt_recv    <= '0;
    end else begin
      case (r_rx_state)
        R_IDLE: begin
          if (w_rx_write) begin
            r_noc_out_ack <= 1'b1;
            r_rx_state    <= R_ACK;
          end
        end
        R_ACK: begin
          if (!w_req_s) begin
            r_noc_out_ack <= 1'b0;
            r_pkt_recv    <= r_pkt_recv + CNT_ONE;
            r_rx_state    <= R_IDLE;
          end
        end
        default: begin
          r_rx_state <= R_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign o_tx_ready     = !w_tx_full;
  assign o_noc_in_req   = r_noc_in_req;
  assign o_noc_in_data  = r_noc_in_data;
  assign o_noc_out_ack  = r_noc_out_ack;
  assign o_rx_valid     = !w_rx_empty;
  assign o_rx_data      = r_rx_mem[r_rx_rptr[AW-1:0]];
  assign o_tx_level     = w_tx_level;
  assign o_rx_level     = w_rx_level;
  assign o_pkt_sent     = r_pkt_sent;
  assign o_pkt_recv     = r_pkt_recv;
  assign o_dbg_tx_state = r_tx_state;
  assign o_dbg_rx_state = r_rx_state;

endmodule

// File: tb/tb_noc_host_interface.sv
// tb_noc_host_interface
// Bench for noc_host_interface: host TX driver, NoC IN responder, NoC OUT
// sender, host RX sink, queue-based scoreboard and a final report.
module tb_noc_host_interface;

  localparam int         WIDTH = 39;
  localparam int         DEPTH = 4;
  localparam logic [7:0] SRC   = 8'h00;
  localparam int         SYNC  = 2;
  localparam int         AW    = $clog2(DEPTH);

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             i_reset = 1'b1;
  logic             i_tx_valid = 1'b0;
  logic             o_tx_ready;
  logic [7:0]       i_tx_dst = '0;
  logic [2:0]       i_tx_type = '0;
  logic [19:0]      i_tx_payload = '0;
  logic             o_noc_in_req;
  logic [WIDTH-1:0] o_noc_in_data;
  logic             i_noc_in_ack = 1'b0;
  logic             i_noc_out_req = 1'b0;
  logic [WIDTH-1:0] i_noc_out_data = '0;
  logic             o_noc_out_ack;
  logic             o_rx_valid;
  logic             i_rx_ready = 1'b0;
  logic [WIDTH-1:0] o_rx_data;
  logic [AW:0]      o_tx_level;
  logic [AW:0]      o_rx_level;
  logic [15:0]      o_pkt_sent;
  logic [15:0]      o_pkt_recv;
  logic [1:0]       o_dbg_tx_state;
  logic             o_dbg_rx_state;

  noc_host_interface #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SRC_ADDR(SRC), .SYNC_STAGES(SYNC)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
    .i_tx_dst(i_tx_dst), .i_tx_type(i_tx_type), .i_tx_payload(i_tx_payload),
    .o_noc_in_req(o_noc_in_req), .o_noc_in_data(o_noc_in_data),
    .i_noc_in_ack(i_noc_in_ack),
    .i_noc_out_req(i_noc_out_req), .i_noc_out_data(i_noc_out_data),
    .o_noc_out_ack(o_noc_out_ack),
    .o_rx_valid(o_rx_valid), .i_rx_ready(i_rx_ready), .o_rx_data(o_rx_data),
    .o_tx_level(o_tx_level), .o_rx_level(o_rx_level),
    .o_pkt_sent(o_pkt_sent), .o_pkt_recv(o_pkt_recv),
    .o_dbg_tx_state(o_dbg_tx_state), .o_dbg_rx_state(o_dbg_rx_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [WIDTH-1:0] tx_exp_q[$];   // packets the NoC IN side must see, in order
  logic [WIDTH-1:0] rx_exp_q[$];   // packets the host must see, in order
  logic [WIDTH-1:0] out_q[$];      // packets waiting to be sent by the NoC OUT model

  int n_in_done  = 0;
  int n_out_done = 0;
  int n_rx_pops  = 0;

  // model knobs
  bit in_auto     = 1'b1;
  bit in_stall    = 1'b0;
  int ack_min     = 3;
  int ack_max     = 3;
  int out_dmin    = 0;
  int out_dmax    = 0;
  bit chk_out_lat = 1'b0;
  int rx_mode     = 1;   // 0 hold, 1 always ready, 2 random, 3 single pop

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Packet as the sum of its weighted fields (dst<<31, src<<23, type<<20).
  function automatic logic [WIDTH-1:0] model_pkt(input logic [7:0] d, input logic [2:0] t,
                                                 input logic [19:0] p);
    logic [63:0] v;
    v = 64'(d) * 64'h8000_0000 + 64'(SRC) * 64'h80_0000 + 64'(t) * 64'h10_0000 + 64'(p);
    return v[WIDTH-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // NoC IN responder: checks every injected packet, acks after a delay
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] in_got;
  int               in_cnt;
  bit               in_stable;
  always begin : noc_in_model
    @(negedge clk);
    if (in_auto && o_noc_in_req) begin
      in_got = o_noc_in_data;
      if (tx_exp_q.size() == 0) check("tx_unexpected", 64'(in_got), 64'h0);
      else                      check("tx_data", 64'(in_got), 64'(tx_exp_q.pop_front()));
      in_cnt = 0;
      while (in_stall && in_cnt < 5000) begin
        @(negedge clk);
        in_cnt++;
      end
      repeat ($urandom_range(ack_min, ack_max)) @(negedge clk);
      i_noc_in_ack = 1'b1;
      in_cnt    = 0;
      in_stable = 1'b1;
      while (o_noc_in_req && in_cnt < 2000) begin
        if (o_noc_in_data !== in_got) in_stable = 1'b0;
        @(negedge clk);
        in_cnt++;
      end
      check("tx_data_stable", 64'(in_stable), 64'h1);
      check("ack_to_req_fall", 64'(in_cnt), 64'(SYNC + 1));
      repeat ($urandom_range(ack_min, ack_max)) @(negedge clk);
      i_noc_in_ack = 1'b0;
      n_in_done++;
    end
  end

  // ---------------------------------------------------------------------
  // NoC OUT sender: 4-phase requester with random spacing
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] out_pkt;
  int               out_cnt;
  always begin : noc_out_model
    @(negedge clk);
    if (out_q.size() > 0) begin
      out_pkt = out_q.pop_front();
      repeat ($urandom_range(out_dmin, out_dmax)) @(negedge clk);
      i_noc_out_data = out_pkt;
      rx_exp_q.push_back(out_pkt);
      @(negedge clk);
      i_noc_out_req = 1'b1;
      out_cnt = 0;
      while (!o_noc_out_ack && out_cnt < 2000) begin
        @(negedge clk);
        out_cnt++;
      end
      if (!o_noc_out_ack)   check("out_ack_timeout", 64'h0, 64'h1);
      else if (chk_out_lat) check("rx_ack_latency", 64'(out_cnt), 64'(SYNC + 1));
      repeat ($urandom_range(out_dmin, out_dmax)) @(negedge clk);
      i_noc_out_req = 1'b0;
      out_cnt = 0;
      while (o_noc_out_ack && out_cnt < 2000) begin
        @(negedge clk);
        out_cnt++;
      end
      if (o_noc_out_ack) check("out_ack_fall_timeout", 64'h0, 64'h1);
      n_out_done++;
    end
  end

  // ---------------------------------------------------------------------
  // Host RX sink: decides ready for the next edge and scores each pop
  // ---------------------------------------------------------------------
  always begin : host_rx_sink
    @(negedge clk);
    case (rx_mode)
      0:       i_rx_ready = 1'b0;
      1, 3:    i_rx_ready = 1'b1;
      default: i_rx_ready = 1'($urandom_range(0, 1));
    endcase
    if (!i_reset && i_rx_ready && o_rx_valid) begin
      if (rx_exp_q.size() == 0) check("rx_unexpected", 64'(o_rx_data), 64'h0);
      else                      check("rx_data", 64'(o_rx_data), 64'(rx_exp_q.pop_front()));
      n_rx_pops++;
      if (rx_mode == 3) rx_mode = 0;
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (called aligned to a falling edge)
  // ---------------------------------------------------------------------
  task automatic push_pkt(input logic [7:0] d, input logic [2:0] t, input logic [19:0] p);
    int budget = 0;
    i_tx_valid   = 1'b1;
    i_tx_dst     = d;
    i_tx_type    = t;
    i_tx_payload = p;
    while (!o_tx_ready && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (!o_tx_ready) check("push_timeout", 64'h0, 64'h1);
    else             tx_exp_q.push_back(model_pkt(d, t, p));
    @(negedge clk);
    i_tx_valid = 1'b0;
  endtask

  task automatic wait_sent(input int target, input string tag);
    int budget = 0;
    while (o_pkt_sent != 16'(target) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check(tag, 64'(o_pkt_sent), 64'(target));
  endtask

  task automatic wait_recv(input int target, input string tag);
    int budget = 0;
    while ((o_pkt_recv != 16'(target) || rx_exp_q.size() != 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check(tag, 64'(o_pkt_recv), 64'(target));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    i_reset = 1'b1;
    tx_exp_q.delete();
    rx_exp_q.delete();
    n_in_done  = 0;
    n_out_done = 0;
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] pkt;
  int               base;
  int               budget;

  initial begin
    // reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_tx_ready", 64'(o_tx_ready), 64'h1);
    check("rst_rx_valid", 64'(o_rx_valid), 64'h0);
    check("rst_in_req", 64'(o_noc_in_req), 64'h0);
    check("rst_out_ack", 64'(o_noc_out_ack), 64'h0);
    check("rst_in_data", 64'(o_noc_in_data), 64'h0);
    check("rst_tx_level", 64'(o_tx_level), 64'h0);
    check("rst_rx_level", 64'(o_rx_level), 64'h0);
    check("rst_pkt_sent", 64'(o_pkt_sent), 64'h0);
    check("rst_pkt_recv", 64'(o_pkt_recv), 64'h0);
    i_reset = 1'b0;
    @(negedge clk);

    // single packet with exact latency; ack after 3 cycles
    ack_min = 3;
    ack_max = 3;
    i_tx_valid   = 1'b1;
    i_tx_dst     = 8'h04;
    i_tx_type    = 3'b001;
    i_tx_payload = 20'h12345;
    check("t1_ready", 64'(o_tx_ready), 64'h1);
    tx_exp_q.push_back(model_pkt(8'h04, 3'b001, 20'h12345));
    @(negedge clk);                                   // after push edge
    i_tx_valid = 1'b0;
    check("t1_req_e0", 64'(o_noc_in_req), 64'h0);
    check("t1_level_e0", 64'(o_tx_level), 64'h1);
    @(negedge clk);                                   // after load edge
    check("t1_req_e1", 64'(o_noc_in_req), 64'h0);
    check("t1_data_e1", 64'(o_noc_in_data), 64'h2_0011_2345);
    check("t1_level_e1", 64'(o_tx_level), 64'h0);
    @(negedge clk);                                   // after setup edge
    check("t1_req_e2", 64'(o_noc_in_req), 64'h1);
    wait_sent(1, "t1_pkt_sent");
    check("t1_level_end", 64'(o_tx_level), 64'h0);
    check("t1_in_done", 64'(n_in_done), 64'h1);

    // five back-to-back pushes while the NoC stalls its ack
    in_stall = 1'b1;
    ack_min  = 0;
    ack_max  = 2;
    for (int k = 0; k < 5; k++)
      push_pkt(8'($urandom), 3'($urandom), 20'($urandom));
    check("t2_tx_ready_full", 64'(o_tx_ready), 64'h0);
    check("t2_tx_level_full", 64'(o_tx_level), 64'(DEPTH));
    repeat (5) @(negedge clk);
    check("t2_req_held", 64'(o_noc_in_req), 64'h1);
    check("t2_still_full", 64'(o_tx_ready), 64'h0);
    in_stall = 1'b0;
    wait_sent(6, "t2_pkt_sent");
    check("t2_tx_exp_empty", 64'(tx_exp_q.size()), 64'h0);

    // three results with payloads 1, 2, 3 and the host always ready
    rx_mode     = 1;
    chk_out_lat = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pkt = {19'($urandom), 20'(k)};
      out_q.push_back(pkt);
    end
    wait_recv(3, "t3_pkt_recv");
    chk_out_lat = 1'b0;
    check("t3_rx_pops", 64'(n_rx_pops), 64'h3);
    check("t3_rx_level", 64'(o_rx_level), 64'h0);

    // RX backpressure: DEPTH+1 results with the host not ready
    rx_mode = 0;
    base    = int'(o_pkt_recv);
    for (int k = 0; k < DEPTH + 1; k++) begin
      pkt = WIDTH'({$urandom, $urandom});
      out_q.push_back(pkt);
    end
    repeat (60) @(negedge clk);
    check("t4_rx_level_full", 64'(o_rx_level), 64'(DEPTH));
    check("t4_pkt_recv", 64'(o_pkt_recv), 64'(base + DEPTH));
    check("t4_req_waiting", 64'(i_noc_out_req), 64'h1);
    check("t4_ack_held_low", 64'(o_noc_out_ack), 64'h0);
    rx_mode = 3;
    budget  = 0;
    while (!o_noc_out_ack && budget < 6) begin
      @(negedge clk);
      budget++;
    end
    check("t4_ack_after_pop", 64'(o_noc_out_ack), 64'h1);
    check("t4_rx_level_refill", 64'(o_rx_level), 64'(DEPTH));
    rx_mode = 1;
    wait_recv(base + DEPTH + 1, "t4_pkt_recv_all");
    check("t4_rx_pops", 64'(n_rx_pops), 64'(3 + DEPTH + 1));

    // reset while a request is outstanding
    in_auto = 1'b0;
    push_pkt(8'h21, 3'd2, 20'hAAAAA);
    push_pkt(8'h13, 3'd5, 20'h55555);
    budget = 0;
    while (!o_noc_in_req && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("t6_req_before_reset", 64'(o_noc_in_req), 64'h1);
    #2 i_reset = 1'b1;
    #1;
    check("t6_req_async_drop", 64'(o_noc_in_req), 64'h0);
    check("t6_tx_level", 64'(o_tx_level), 64'h0);
    check("t6_rx_level", 64'(o_rx_level), 64'h0);
    check("t6_pkt_sent", 64'(o_pkt_sent), 64'h0);
    check("t6_pkt_recv", 64'(o_pkt_recv), 64'h0);
    check("t6_in_data", 64'(o_noc_in_data), 64'h0);
    @(negedge clk);
    i_reset = 1'b0;
    tx_exp_q.delete();
    n_in_done = 0;
    in_auto   = 1'b1;
    @(negedge clk);
    push_pkt(8'h31, 3'd7, 20'hBEEF1);
    wait_sent(1, "t6_pkt_sent_after");
    check("t6_tx_exp_empty", 64'(tx_exp_q.size()), 64'h0);

    // concurrent TX and RX, 20 packets each, random delays 0..5
    apply_reset();
    ack_min  = 0;
    ack_max  = 5;
    out_dmin = 0;
    out_dmax = 5;
    rx_mode  = 2;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_pkt(8'($urandom), 3'($urandom), 20'($urandom));
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          pkt = WIDTH'({$urandom, $urandom});
          out_q.push_back(pkt);
        end
      end
    join
    wait_sent(20, "t5_pkt_sent");
    wait_recv(20, "t5_pkt_recv");
    check("t5_tx_exp_empty", 64'(tx_exp_q.size()), 64'h0);
    check("t5_rx_exp_empty", 64'(rx_exp_q.size()), 64'h0);
    check("t5_in_done", 64'(n_in_done), 64'd20);
    check("t5_out_done", 64'(n_out_done), 64'd20);
    check("t5_rx_valid_idle", 64'(o_rx_valid), 64'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
